// File: rtl/image_packer_if.sv
// Handshake bundle between the pixel stream source, the packer and the classifier.
// Signal names are taken from the packer's point of view.
interface image_packer_if #(
   parameter int PIXELS  = 784,
   parameter int PIXEL_W = 8
);
   logic               valid_i;
   logic [PIXEL_W-1:0] pixel_i;
   logic               sof_i;
   logic               ready_o;
   logic               valid_o;
   logic [PIXELS-1:0]  data_o;
   logic               ready_i;
   logic               resync_o;

   modport slave (
      input  valid_i, pixel_i, sof_i, ready_i,
      output ready_o, valid_o, data_o, resync_o
   );

   modport master (
      output valid_i, pixel_i, sof_i, ready_i,
      input  ready_o, valid_o, data_o, resync_o
   );
endinterface

// File: rtl/image_packer.sv
// Binarizes a serial grayscale pixel stream and packs one full frame into a bit-vector
// handed to the classifier over valid/ready; sof on a partial frame restarts packing.
module image_packer #(
   parameter int                 PIXELS    = 784,
   parameter int                 PIXEL_W   = 8,
   parameter logic [PIXEL_W-1:0] THRESHOLD = PIXEL_W'(128)
) (
   input  logic          clk_i,
   input  logic          reset_i,
   image_packer_if.slave bus
);
   localparam int               CNT_W    = $clog2(PIXELS);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PIXELS - 1);

   typedef enum logic [0:0] {
      ST_FILL = 1'b0,
      ST_SEND = 1'b1
   } state_e;

   state_e            state_q;
   logic [CNT_W-1:0]  count_q;
   logic [PIXELS-1:0] frame_q;
   logic              valid_q;
   logic              ready_q;
   logic              resync_q;
   logic              pixel_bit;

   assign pixel_bit = (bus.pixel_i >= THRESHOLD);

   // ready/valid flops always mirror the state they are written with, so the handshake
   // outputs stay purely registered.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= ST_FILL;
         count_q  <= {CNT_W{1'b0}};
         frame_q  <= {PIXELS{1'b0}};
         valid_q  <= 1'b0;
         ready_q  <= 1'b1;
         resync_q <= 1'b0;
      end else begin
         resync_q <= 1'b0;
         case (state_q)
            ST_FILL: begin
               if (bus.valid_i) begin
                  if (bus.sof_i && (count_q != {CNT_W{1'b0}})) begin
                     frame_q  <= {{(PIXELS-1){1'b0}}, pixel_bit};
                     count_q  <= CNT_W'(1);
                     resync_q <= 1'b1;
                  end else begin
                     frame_q[count_q] <= pixel_bit;
                     if (count_q == LAST_IDX) begin
                        count_q <= {CNT_W{1'b0}};
                        state_q <= ST_SEND;
                        valid_q <= 1'b1;
                        ready_q <= 1'b0;
                     end else begin
                        count_q <= count_q + CNT_W'(1);
                     end
                  end
               end
            end
            ST_SEND: begin
               if (bus.ready_i) begin
                  state_q <= ST_FILL;
                  count_q <= {CNT_W{1'b0}};
                  frame_q <= {PIXELS{1'b0}};
                  valid_q <= 1'b0;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_FILL;
               count_q <= {CNT_W{1'b0}};
               frame_q <= {PIXELS{1'b0}};
               valid_q <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.ready_o  = ready_q;
   assign bus.valid_o  = valid_q;
   assign bus.data_o   = frame_q;
   assign bus.resync_o = resync_q;
endmodule

// File: tb/tb_image_packer.sv
// Randomized bench for image_packer; expected frames come from a queue-based model of
// the binarize/pack/resync rules.
module tb_image_packer;
   localparam int PIXELS = 784;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   resync_cnt = 0;

   bit                model_q[$];
   logic [PIXELS-1:0] exp_frame = '0;
   bit                model_resync = 1'b0;
   logic [7:0]        pix_a [PIXELS];

   image_packer_if #(.PIXELS(PIXELS), .PIXEL_W(8)) bus ();

   image_packer #(.PIXELS(PIXELS), .PIXEL_W(8), .THRESHOLD(8'd128)) dut (
      .clk_i  (clk),
      .reset_i(rst),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (bus.resync_o === 1'b1) resync_cnt++;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // model: collect bits in order; sof on a non-empty frame starts over
   function automatic void model_accept(input logic [7:0] pix, input logic sof);
      if (sof && model_q.size() != 0) begin
         model_q.delete();
         model_resync = 1'b1;
      end
      model_q.push_back(pix >= 8'd128);
      if (model_q.size() == PIXELS) begin
         for (int k = 0; k < PIXELS; k++) exp_frame[k] = model_q[k];
         model_q.delete();
      end
   endfunction

   task automatic beat(input logic [7:0] pix, input logic sof, input logic vld, output bit acc);
      @(negedge clk);
      bus.valid_i = vld;
      bus.pixel_i = pix;
      bus.sof_i   = sof;
      acc = vld && (bus.ready_o === 1'b1) && !rst;
      @(posedge clk);
      #1;
      bus.valid_i = 1'b0;
      if (acc) model_accept(pix, sof);
   endtask

   task automatic push(input logic [7:0] pix, input logic sof, input int duty);
      bit acc = 1'b0;
      int tries = 0;
      while (!acc && tries < 1000) begin
         if (int'($urandom_range(99)) < duty) beat(pix, sof, 1'b1, acc);
         else beat(8'($urandom), 1'($urandom), 1'b0, acc);
         tries++;
      end
      if (!acc) begin
         checks++; errors++;
         $display("FAIL push_timeout accepted=0 required=1");
      end
   endtask

   task automatic send_range(input int first, input int last, input int duty);
      for (int k = first; k <= last; k++) push(pix_a[k], 1'b0, duty);
   endtask

   task automatic randomize_pixels();
      for (int k = 0; k < PIXELS; k++) pix_a[k] = 8'($urandom);
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1 || bus.data_o !== '0 || bus.resync_o !== 1'b0)
         begin errors++; $display("FAIL reset_state valid=%b ready=%b resync=%b required 0/1/0, data zero", bus.valid_o, bus.ready_o, bus.resync_o); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_single_frame();
      bus.ready_i = 1'b1;
      for (int k = 0; k < PIXELS; k++) pix_a[k] = (k % 2 == 1) ? 8'd200 : 8'd50;
      send_range(0, PIXELS-2, 100);
      checks++;
      if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL single_early_valid actual=%b required=0", bus.valid_o); end
      send_range(PIXELS-1, PIXELS-1, 100);
      checks++;
      if (bus.valid_o !== 1'b1 || bus.ready_o !== 1'b0)
         begin errors++; $display("FAIL single_handshake valid=%b ready=%b required 1/0", bus.valid_o, bus.ready_o); end
      checks++;
      if (bus.data_o !== exp_frame) begin errors++; $display("FAIL single_data actual=%h required=%h", bus.data_o, exp_frame); end
      @(posedge clk); #1;
      checks++;
      if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1 || bus.data_o !== '0)
         begin errors++; $display("FAIL single_delivery valid=%b ready=%b required 0/1 and cleared data", bus.valid_o, bus.ready_o); end
   endtask

   task automatic test_threshold();
      logic [3:0] low4;
      for (int k = 0; k < PIXELS; k++) pix_a[k] = 8'd0;
      pix_a[0] = 8'd127; pix_a[1] = 8'd128; pix_a[2] = 8'd0; pix_a[3] = 8'd255;
      send_range(0, PIXELS-1, 100);
      low4 = bus.data_o[3:0];
      checks++;
      if (low4 !== 4'b1010 || $countones(bus.data_o) != 2)
         begin errors++; $display("FAIL threshold_bits actual=%b ones=%0d required=1010 ones=2", low4, $countones(bus.data_o)); end
      checks++;
      if (bus.data_o !== exp_frame) begin errors++; $display("FAIL threshold_data actual=%h required=%h", bus.data_o, exp_frame); end
      @(posedge clk); #1;
   endtask

   task automatic test_random_frames();
      for (int f = 0; f < 3; f++) begin
         randomize_pixels();
         send_range(0, PIXELS-1, 100);
         checks++;
         if (bus.valid_o !== 1'b1 || bus.data_o !== exp_frame)
            begin errors++; $display("FAIL random_frame%0d valid=%b actual=%h required=%h", f, bus.valid_o, bus.data_o, exp_frame); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_backpressure();
      bit acc;
      bus.ready_i = 1'b0;
      for (int k = 0; k < PIXELS; k++) pix_a[k] = 8'd255;
      send_range(0, PIXELS-1, 100);
      checks++;
      if (bus.data_o !== exp_frame || bus.valid_o !== 1'b1)
         begin errors++; $display("FAIL bp_frame valid=%b actual=%h required=%h", bus.valid_o, bus.data_o, exp_frame); end
      for (int c = 0; c < 50; c++) begin
         beat(8'($urandom), 1'($urandom), 1'b1, acc);
         checks++;
         if (bus.valid_o !== 1'b1 || bus.ready_o !== 1'b0 || bus.data_o !== {PIXELS{1'b1}})
            begin errors++; $display("FAIL bp_hold cycle=%0d valid=%b ready=%b ones=%0d required 1/0/784", c, bus.valid_o, bus.ready_o, $countones(bus.data_o)); end
      end
      @(negedge clk); bus.ready_i = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1)
         begin errors++; $display("FAIL bp_release valid=%b ready=%b required 0/1", bus.valid_o, bus.ready_o); end
      for (int k = 0; k < PIXELS; k++) pix_a[k] = (k == 0) ? 8'd255 : 8'd0;
      send_range(0, PIXELS-1, 100);
      checks++;
      if (bus.data_o !== exp_frame) begin errors++; $display("FAIL bp_next_frame actual=%h required=%h", bus.data_o, exp_frame); end
      @(posedge clk); #1;
   endtask

   task automatic test_resync();
      int r0 = resync_cnt;
      model_resync = 1'b0;
      for (int k = 0; k < 300; k++) push(8'd255, 1'b0, 100);
      push(8'd255, 1'b1, 100);
      checks++;
      if (bus.resync_o !== model_resync) begin errors++; $display("FAIL resync_pulse actual=%b required=%b", bus.resync_o, model_resync); end
      for (int k = 0; k < PIXELS-2; k++) push(8'd0, 1'b0, 100);
      checks++;
      if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL resync_early_valid actual=%b required=0", bus.valid_o); end
      push(8'd0, 1'b0, 100);
      checks++;
      if (bus.valid_o !== 1'b1 || bus.data_o !== exp_frame)
         begin errors++; $display("FAIL resync_frame valid=%b actual=%h required=%h", bus.valid_o, bus.data_o, exp_frame); end
      checks++;
      if (resync_cnt - r0 != 1) begin errors++; $display("FAIL resync_count actual=%0d required=1", resync_cnt - r0); end
      @(posedge clk); #1;
   endtask

   task automatic test_sof_last();
      randomize_pixels();
      model_resync = 1'b0;
      send_range(0, PIXELS-2, 100);
      push(8'd255, 1'b1, 100);
      checks++;
      if (bus.resync_o !== model_resync || bus.valid_o !== 1'b0)
         begin errors++; $display("FAIL sof_last resync=%b valid=%b required %b/0", bus.resync_o, bus.valid_o, model_resync); end
      randomize_pixels();
      send_range(1, PIXELS-1, 100);
      checks++;
      if (bus.valid_o !== 1'b1 || bus.data_o !== exp_frame)
         begin errors++; $display("FAIL sof_last_frame valid=%b actual=%h required=%h", bus.valid_o, bus.data_o, exp_frame); end
      @(posedge clk); #1;
   endtask

   task automatic test_bubbles();
      for (int k = 0; k < PIXELS; k++)
         pix_a[k] = (k == 0 || k == 27 || k == 28 || k == PIXELS-1) ? 8'd255 : 8'($urandom_range(127));
      send_range(0, PIXELS-1, 50);
      checks++;
      if (bus.data_o !== exp_frame || $countones(bus.data_o) != 4)
         begin errors++; $display("FAIL bubbles_data ones=%0d actual=%h required=%h", $countones(bus.data_o), bus.data_o, exp_frame); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      bus.ready_i = 1'b1;
      randomize_pixels();
      send_range(0, 499, 100);
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1 || bus.data_o !== '0 || bus.resync_o !== 1'b0)
         begin errors++; $display("FAIL reset_mid valid=%b ready=%b ones=%0d required 0/1/0", bus.valid_o, bus.ready_o, $countones(bus.data_o)); end
      model_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      randomize_pixels();
      send_range(0, PIXELS-1, 100);
      checks++;
      if (bus.valid_o !== 1'b1 || bus.data_o !== exp_frame)
         begin errors++; $display("FAIL reset_mid_next valid=%b actual=%h required=%h", bus.valid_o, bus.data_o, exp_frame); end
      @(posedge clk); #1;

      bus.ready_i = 1'b0;
      randomize_pixels();
      send_range(0, PIXELS-1, 100);
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1 || bus.data_o !== '0)
         begin errors++; $display("FAIL reset_send valid=%b ready=%b ones=%0d required 0/1/0", bus.valid_o, bus.ready_o, $countones(bus.data_o)); end
      model_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      bus.ready_i = 1'b1;
      randomize_pixels();
      send_range(0, PIXELS-1, 100);
      checks++;
      if (bus.valid_o !== 1'b1 || bus.data_o !== exp_frame)
         begin errors++; $display("FAIL reset_send_next valid=%b actual=%h required=%h", bus.valid_o, bus.data_o, exp_frame); end
      @(posedge clk); #1;
   endtask

   initial begin
      bus.valid_i = 1'b0;
      bus.pixel_i = 8'd0;
      bus.sof_i   = 1'b0;
      bus.ready_i = 1'b1;
      test_reset();
      test_single_frame();
      test_threshold();
      test_random_frames();
      test_backpressure();
      test_resync();
      test_sof_last();
      test_bubbles();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/image_packer.md
# image_packer

Front-end block that feeds the digit classifier. It accepts a serial stream of 8-bit grayscale pixels over a valid/ready handshake and binarizes each pixel against a threshold. It packs one full 28x28 frame into a 784-bit bit-vector and presents that vector on a valid/ready output, matching the classifier's `valid_i` / `data_i[783:0]` / `ready_o` input port.

## Interface

Parameters:
- `PIXELS`, 784: pixels per frame; also the width of `data_o`.
- `PIXEL_W`, 8: width of one input pixel.
- `THRESHOLD`, 128: binarization threshold, unsigned, same width as `PIXEL_W`.

Ports:
- `clk_i`, input, 1: single clock; all state changes on the rising edge.
- `reset_i`, input, 1: asynchronous, active-high reset.
- `valid_i`, input, 1: upstream pixel valid.
- `pixel_i`, input, `PIXEL_W`: unsigned grayscale pixel.
- `sof_i`, input, 1: start-of-frame marker, qualified by `valid_i`.
- `ready_o`, output, 1: block can accept a pixel this cycle.
- `valid_o`, output, 1: `data_o` holds a complete frame.
- `data_o`, output, `PIXELS`: packed binary frame; bit k is pixel k.
- `ready_i`, input, 1: downstream (classifier) accepts the frame.
- `resync_o`, output, 1: one-cycle pulse when `sof_i` restarts a partially filled frame.

## Operation

- Two states:
  - FILL: collecting pixels.
  - SEND: holding a complete frame.
- Reset values (asynchronous, applied immediately):
  - state = FILL, pixel count = 0, frame register = 0.
  - `valid_o` = 0, `ready_o` = 1, `resync_o` = 0.
- Beats arriving while `reset_i` is high are not accepted.
- `ready_o` = 1 exactly when state is FILL. `valid_o` = 1 exactly when state is SEND. Both are decoded from registered state only.
- Pixel accept occurs when `valid_i && ready_o` at a rising edge.
- Binarization: bit = 1 iff `pixel_i >= THRESHOLD`, unsigned compare.
  - Pixel value 0 gives 0; 255 gives 1; 127 gives 0; 128 gives 1 (at the default threshold).
- Normal accept (`sof_i` = 0, or `sof_i` = 1 with count = 0):
  - The bit is written to frame-register index `count`.
  - `count` increments.
- Resync accept (`sof_i` = 1 and count != 0):
  - Frame register is cleared.
  - The bit is written to index 0 and count becomes 1.
  - `resync_o` pulses high for the following cycle.
  - This applies in FILL only; `sof_i` in SEND is ignored because no accept happens.
- Completion: when the accepted pixel has index `PIXELS-1`:
  - Count wraps to 0.
  - State goes to SEND on the same edge.
- A `sof_i` arriving on the final pixel is a resync, not a completion: the frame restarts at index 1.
- SEND:
  - `data_o` is held stable; `ready_o` = 0; upstream stalls.
  - When `ready_i` = 1 at an edge, the frame is delivered.
  - On delivery: state returns to FILL, frame register is cleared, count = 0.
- Downstream may hold `ready_i` low indefinitely; the block remains in SEND with no data loss and no pixel accepts.
- `ready_i` is ignored while in FILL.
- `valid_i` low in FILL leaves count and register unchanged. Bubbles are permitted anywhere in a frame.
- Count register width is $clog2(`PIXELS`). The count never exceeds `PIXELS-1`.
- Reset asserted mid-frame or in SEND discards the partial or held frame. After release the block is in FILL at index 0.

## Timing

- Throughput: one pixel per cycle in FILL.
- The frame occupies `PIXELS` accept cycles plus at least 1 SEND cycle, so minimum period = `PIXELS`+1 cycles per frame.
- `valid_o` rises on the edge that accepts pixel `PIXELS-1`, so it is visible in the next cycle.
- `ready_o` falls on that same edge.
- Output handshake at edge T: `valid_o` = 0 and `ready_o` = 1 from T onward. The first pixel of the next frame can be accepted at edge T+1.
- No combinational path from any input to any output; `data_o` comes directly from the frame register.
- `resync_o` is registered. It is high exactly one cycle, following the resync accept edge.

## Test plan

- **Single frame.** Reset, then stream 784 pixels with pixel k = (k mod 2) ? 200 : 50, `ready_i` = 1.
  - `valid_o` is high exactly one cycle, the cycle after the 784th accept.
  - `data_o` has odd bits = 1 and even bits = 0.
  - `ready_o` is low for that cycle only.
- **Threshold edges.** Pixels 0 to 3 = 127, 128, 0, 255; remaining pixels = 0.
  - `data_o[3:0]` = 4'b1010; all other bits are 0.
- **Backpressure.** Complete a frame with all pixels = 255, hold `ready_i` = 0 for 50 cycles while `valid_i` stays high.
  - `valid_o` stays 1, `data_o` stays all-ones, `ready_o` stays 0, and no pixels are consumed.
  - After `ready_i` = 1, the next frame starts at index 0.
- **Resync.** Send 300 pixels of 255, then a beat with `sof_i` = 1 and pixel 255, then 783 pixels of 0.
  - `resync_o` pulses once.
  - The delivered frame has only bit 0 set, with `valid_o` arriving after 784 post-sof accepts.
- **Bubbles and order.** Random `valid_i` duty (~50%), pixel k = 255 only for k in {0, 27, 28, 783}.
  - Exactly those four bits are set.
- **Reset mid-operation.** Assert `reset_i` asynchronously after 500 pixels, and separately while in SEND.
  - Outputs immediately go to `valid_o` = 0, `ready_o` = 1 (after release), `data_o` = 0.
  - The next full frame is packed correctly from index 0.
